bnn_layer_seq: RTL and testbench

Sequential, parametrised binary-neural-network layer for the medical-vitals classifier. It evaluates NEURONS binarised neurons in parallel on a sample that arrives as BEATS beats of IN_W binarised features, using XNOR-popcount accumulation. Per-neuron weights and thresholds are runtime-programmable. Results are delivered over a valid/ready output port. It replaces the single fixed-weight, single-beat combinational neuron as the classifier core.

---
 rtl/bnn_layer_seq.sv | 156 +++++++++++++++
 tb/tb_bnn_layer_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_layer_seq.sv
// Sequential binarised neural-network layer: XNOR-popcount accumulation over BEATS input
// beats, runtime-programmable weights and thresholds, and a valid/ready result port.
module bnn_layer_seq #(
    parameter int IN_W = 8,
    parameter int BEATS = 4,
    parameter int NEURONS = 4,
    parameter logic [IN_W-1:0] DEF_W = 8'hF3,
    parameter int DEF_THR = 20,
    localparam int CNT_W = $clog2(IN_W * BEATS + 1),
    localparam int NI_W = (NEURONS > 1) ? $clog2(NEURONS) : 1,
    localparam int BI_W = $clog2(BEATS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [NI_W-1:0]          cfg_neuron,
    input  logic [BI_W-1:0]          cfg_beat,
    input  logic [IN_W-1:0]          cfg_data,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NEURONS-1:0]       out_class,
    output logic [NEURONS*CNT_W-1:0] out_scores,
    output logic                     busy,
    output logic                     dbg_state
);

    // Valid/ready: a beat moves on any edge where in_valid & in_ready are both high; a result
    // moves on any edge where out_valid & out_ready are both high. Neither valid waits on ready.
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t                     state_q, state_d;
    logic [BI_W-1:0]            k_q, k_d;
    logic [CNT_W-1:0]           acc_q [NEURONS];
    logic [CNT_W-1:0]           acc_d [NEURONS];
    logic [IN_W-1:0]            w_q [NEURONS][BEATS];
    logic [IN_W-1:0]            w_d [NEURONS][BEATS];
    logic [CNT_W-1:0]           thr_q [NEURONS];
    logic [CNT_W-1:0]           thr_d [NEURONS];
    logic                       out_valid_q, out_valid_d;
    logic [NEURONS-1:0]         out_class_q, out_class_d;
    logic [NEURONS*CNT_W-1:0]   out_scores_q, out_scores_d;

    logic [IN_W-1:0]            sel_w [NEURONS];
    logic [CNT_W-1:0]           sum [NEURONS];
    logic                       accept;
    logic                       last_beat;

    function automatic logic [CNT_W-1:0] popcnt(input logic [IN_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < IN_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    assign in_ready   = (state_q == ACCUM) && !cfg_we;
    assign accept     = in_valid && in_ready;
    assign last_beat  = (k_q == BI_W'(BEATS - 1));
    assign out_valid  = out_valid_q;
    assign out_class  = out_class_q;
    assign out_scores = out_scores_q;
    assign busy       = (k_q != '0);
    assign dbg_state  = (state_q == HOLD);

    // Running score including the beat currently on in_data, per neuron.
    always_comb begin
        for (int n = 0; n < NEURONS; n++) begin
            sel_w[n] = '0;
            for (int b = 0; b < BEATS; b++) begin
                if (k_q == BI_W'(b)) sel_w[n] = w_q[n][b];
            end
            sum[n] = acc_q[n] + popcnt(~(in_data ^ sel_w[n]));
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        acc_d        = acc_q;
        w_d          = w_q;
        thr_d        = thr_q;
        out_valid_d  = out_valid_q;
        out_class_d  = out_class_q;
        out_scores_d = out_scores_q;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (last_beat) begin
                        for (int n = 0; n < NEURONS; n++) begin
                            out_scores_d[n*CNT_W +: CNT_W] = sum[n];
                            out_class_d[n] = (sum[n] >= thr_q[n]);
                            acc_d[n] = '0;
                        end
                        k_d         = '0;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        acc_d = sum;
                        k_d   = k_q + BI_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase

        // Addresses that match no loop index are out of range and simply fall through.
        if (cfg_we) begin
            for (int n = 0; n < NEURONS; n++) begin
                if (cfg_neuron == NI_W'(n)) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (cfg_beat == BI_W'(b)) w_d[n][b] = cfg_data;
                    end
                    if (cfg_beat == BI_W'(BEATS)) thr_d[n] = cfg_data[CNT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACCUM;
            k_q          <= '0;
            out_valid_q  <= 1'b0;
            out_class_q  <= '0;
            out_scores_q <= '0;
            for (int n = 0; n < NEURONS; n++) begin
                acc_q[n] <= '0;
                thr_q[n] <= CNT_W'(DEF_THR);
                for (int b = 0; b < BEATS; b++) begin
                    w_q[n][b] <= DEF_W;
                end
            end
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            w_q          <= w_d;
            thr_q        <= thr_d;
            out_valid_q  <= out_valid_d;
            out_class_q  <= out_class_d;
            out_scores_q <= out_scores_d;
        end
    end

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Bench for bnn_layer_seq: directed and randomized samples checked against a per-neuron
// XNOR-popcount reference model of weights and thresholds.
module tb_bnn_layer_seq;

    localparam int IN_W = 8;
    localparam int BEATS = 4;
    localparam int NEURONS = 4;
    localparam int CNT_W = 6;
    localparam int RES_W = NEURONS + NEURONS * CNT_W;

    logic                     clk;
    logic                     rst;
    logic                     cfg_we;
    logic [1:0]               cfg_neuron;
    logic [2:0]               cfg_beat;
    logic [IN_W-1:0]          cfg_data;
    logic                     in_valid;
    logic [IN_W-1:0]          in_data;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [NEURONS-1:0]       out_class;
    logic [NEURONS*CNT_W-1:0] out_scores;
    logic                     busy;
    logic                     dbg_state;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] mw [NEURONS][BEATS];
    logic [5:0] mthr [NEURONS];
    logic [RES_W-1:0] exp_q [$];

    bnn_layer_seq dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_neuron(cfg_neuron),
        .cfg_beat(cfg_beat), .cfg_data(cfg_data), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_class(out_class), .out_scores(out_scores),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int n = 0; n < NEURONS; n++) begin
            mthr[n] = 6'd20;
            for (int b = 0; b < BEATS; b++) mw[n][b] = 8'hF3;
        end
    endtask

    function automatic int exp_score(int n, logic [31:0] smp);
        int s;
        logic [7:0] m;
        s = 0;
        for (int b = 0; b < BEATS; b++) begin
            m = ~(smp[b*8 +: 8] ^ mw[n][b]);
            s += $countones(m);
        end
        return s;
    endfunction

    function automatic logic [RES_W-1:0] exp_result(logic [31:0] smp);
        logic [NEURONS-1:0] c;
        logic [NEURONS*CNT_W-1:0] s;
        int sc;
        for (int n = 0; n < NEURONS; n++) begin
            sc = exp_score(n, smp);
            s[n*CNT_W +: CNT_W] = sc[5:0];
            c[n] = (sc >= int'(mthr[n]));
        end
        return {c, s};
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cfg_write(int n, int b, logic [7:0] d);
        cfg_we = 1'b1;
        cfg_neuron = n[1:0];
        cfg_beat = b[2:0];
        cfg_data = d;
        step();
        cfg_we = 1'b0;
        if (b < BEATS) mw[n][b] = d;
        else if (b == BEATS) mthr[n] = d[5:0];
    endtask

    task automatic drive_beats(logic [31:0] smp, int first, int count);
        for (int b = first; b < first + count; b++) begin
            in_valid = 1'b1;
            in_data = smp[b*8 +: 8];
            step();
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rep4(logic [7:0] v);
        return {v, v, v, v};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        step();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_class !== 4'b0000) $display("FAIL reset_out_class got %b want 0000", out_class); else pass_cnt++;
        total_cnt++; if (out_scores !== '0) $display("FAIL reset_out_scores got %h want 0", out_scores); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [RES_W-1:0] want;
        out_ready = 1'b1;
        drive_beats(rep4(8'hF3), 0, 3);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else pass_cnt++;
        drive_beats(rep4(8'hF3), 3, 1);
        want = {4'b1111, 6'd32, 6'd32, 6'd32, 6'd32};
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if ({out_class, out_scores} !== want) $display("FAIL basic_result got %h want %h", {out_class, out_scores}, want); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_end got %b want 0", busy); else pass_cnt++;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_valid_one_cycle got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready_after got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_patterns();
        logic [RES_W-1:0] want;
        out_ready = 1'b1;
        drive_beats(rep4(8'h0C), 0, 4);
        want = {4'b0000, 24'd0};
        total_cnt++; if ({out_class, out_scores} !== want) $display("FAIL pat_0c got %h want %h", {out_class, out_scores}, want); else pass_cnt++;
        step();
        drive_beats(rep4(8'hF0), 0, 4);
        want = {4'b1111, 6'd24, 6'd24, 6'd24, 6'd24};
        total_cnt++; if ({out_class, out_scores} !== want) $display("FAIL pat_f0 got %h want %h", {out_class, out_scores}, want); else pass_cnt++;
        step();
    endtask

    task automatic test_cfg();
        out_ready = 1'b1;
        cfg_write(2, 4, 8'd33);
        drive_beats(rep4(8'hF3), 0, 4);
        total_cnt++; if (out_class !== 4'b1011) $display("FAIL cfg_thr33 got %b want 1011", out_class); else pass_cnt++;
        step();
        cfg_write(1, 0, 8'h00);
        cfg_write(3, 4, 8'd32);
        drive_beats(rep4(8'hF3), 0, 4);
        total_cnt++; if (out_scores[1*CNT_W +: CNT_W] !== 6'd26) $display("FAIL cfg_w10_score got %0d want 26", out_scores[1*CNT_W +: CNT_W]); else pass_cnt++;
        total_cnt++; if (out_class !== 4'b1011) $display("FAIL cfg_thr_equal got %b want 1011", out_class); else pass_cnt++;
        total_cnt++; if ({out_class, out_scores} !== exp_result(rep4(8'hF3))) $display("FAIL cfg_model got %h want %h", {out_class, out_scores}, exp_result(rep4(8'hF3))); else pass_cnt++;
        step();
    endtask

    task automatic test_hold();
        logic [31:0] smp;
        logic [RES_W-1:0] want;
        smp = $urandom;
        out_ready = 1'b0;
        drive_beats(smp, 0, 4);
        want = exp_result(smp);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) cfg_write(0, 4, 8'd0);
            else if (c == 2) cfg_write(1, 4, 8'd40);
            else step();
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL hold_valid c%0d got %b want 1", c, out_valid); else pass_cnt++;
            total_cnt++; if ({out_class, out_scores} !== want) $display("FAIL hold_stable c%0d got %h want %h", c, {out_class, out_scores}, want); else pass_cnt++;
            total_cnt++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready c%0d got %b want 0", c, in_ready); else pass_cnt++;
            total_cnt++; if (dbg_state !== 1'b1) $display("FAIL hold_state c%0d got %b want 1", c, dbg_state); else pass_cnt++;
        end
        out_ready = 1'b1;
        step();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL hold_release_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL hold_release_ready got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [RES_W-1:0] want;
        out_ready = 1'b1;
        drive_beats(rep4(8'h0C), 0, 2);
        total_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy_before got %b want 1", busy); else pass_cnt++;
        do_reset();
        total_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy_after got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_valid_after got %b want 0", out_valid); else pass_cnt++;
        drive_beats(rep4(8'hF3), 0, 4);
        want = {4'b1111, 6'd32, 6'd32, 6'd32, 6'd32};
        total_cnt++; if ({out_class, out_scores} !== want) $display("FAIL mid_fresh got %h want %h", {out_class, out_scores}, want); else pass_cnt++;
        // A held result is dropped by reset as well.
        out_ready = 1'b0;
        do_reset();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_drop_held got %b want 0", out_valid); else pass_cnt++;
        out_ready = 1'b1;
    endtask

    task automatic test_cfg_priority();
        logic [31:0] smp;
        smp = $urandom;
        out_ready = 1'b1;
        drive_beats(smp, 0, 1);
        in_valid = 1'b1;
        in_data = ~smp[15:8];
        cfg_we = 1'b1;
        cfg_neuron = 2'd0;
        cfg_beat = 3'd2;
        cfg_data = 8'h3C;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL prio_in_ready got %b want 0", in_ready); else pass_cnt++;
        step();
        cfg_we = 1'b0;
        in_valid = 1'b0;
        mw[0][2] = 8'h3C;
        drive_beats(smp, 1, 3);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL prio_valid got %b want 1", out_valid); else pass_cnt++;
        total_cnt++; if ({out_class, out_scores} !== exp_result(smp)) $display("FAIL prio_result got %h want %h", {out_class, out_scores}, exp_result(smp)); else pass_cnt++;
        step();
        cfg_write(1, 5, 8'h00);
        cfg_write(2, 7, 8'h00);
        cfg_write(3, 6, 8'hFF);
        smp = $urandom;
        drive_beats(smp, 0, 4);
        total_cnt++; if ({out_class, out_scores} !== exp_result(smp)) $display("FAIL oor_write got %h want %h", {out_class, out_scores}, exp_result(smp)); else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] smp;
        logic [RES_W-1:0] want;
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < NEURONS; n++) begin
                for (int b = 0; b < BEATS; b++) cfg_write(n, b, 8'($urandom));
                cfg_write(n, 4, 8'($urandom_range(0, 40)));
            end
            smp = $urandom;
            for (int i = 0; i < 6; i++) begin
                exp_q.push_back(exp_result(smp));
                drive_beats(smp, 0, 4);
                want = exp_q.pop_front();
                total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid r%0d i%0d got %b want 1", r, i, out_valid); else pass_cnt++;
                total_cnt++; if ({out_class, out_scores} !== want) $display("FAIL b2b_result r%0d i%0d got %h want %h", r, i, {out_class, out_scores}, want); else pass_cnt++;
                smp = $urandom;
                in_valid = 1'b1;
                in_data = smp[7:0];
                total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_hold_ready r%0d i%0d got %b want 0", r, i, in_ready); else pass_cnt++;
                step();
                total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_release r%0d i%0d got %b want 0", r, i, out_valid); else pass_cnt++;
            end
            in_valid = 1'b0;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        cfg_we = 1'b0;
        cfg_neuron = '0;
        cfg_beat = '0;
        cfg_data = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_patterns();
        test_cfg();
        test_hold();
        test_reset_mid();
        test_cfg_priority();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
